// File: rtl/uart_tx_sched.sv
// ICB bus master that configures a UART after reset and then shares its
// transmitter between two byte requesters with round-robin arbitration.
module uart_tx_sched #(
  parameter int unsigned          PA_SIZE   = 32,
  parameter logic [PA_SIZE-1:0]   DATA_ADDR = 32'h1000_0000,
  parameter logic [PA_SIZE-1:0]   CSR_ADDR  = 32'h1000_0004,
  parameter logic [PA_SIZE-1:0]   CTRL_ADDR = 32'h1000_0008,
  parameter logic [31:0]          CTRL_INIT = 32'h0000_1111,
  parameter logic [15:0]          DIVISOR   = 16'd54,
  parameter int unsigned          HOLDOFF   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [7:0]         req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [7:0]         req1_data,
  output logic               req1_ready,
  output logic               done,
  output logic               done_id,
  output logic               init_done,
  output logic               busy,
  output logic               icb_cmd_valid,
  input  logic               icb_cmd_ready,
  output logic [PA_SIZE-1:0] icb_cmd_addr,
  output logic               icb_cmd_read,
  output logic [31:0]        icb_cmd_wdata,
  input  logic               icb_rsp_valid,
  output logic               icb_rsp_ready,
  input  logic [31:0]        icb_rsp_rdata
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF - 1);

  typedef enum logic [3:0] {
    INIT_CTRL,
    INIT_CTRL_RSP,
    INIT_CSR,
    INIT_CSR_RSP,
    IDLE,
    POLL,
    POLL_RSP,
    WRITE,
    WRITE_RSP,
    HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       byte_q;
  logic             id_q;
  logic             rr_last;
  logic [CNT_W-1:0] hold_cnt;
  logic             grant0, grant1;
  logic             write_done;

  // Only tx_ok (bit 0) of the CSR read data matters here.
  logic rdata_unused;
  assign rdata_unused = ^icb_rsp_rdata[31:1];

  assign write_done = (state == WRITE_RSP) && icb_rsp_valid;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      INIT_CTRL:     if (icb_cmd_ready) state_nxt = INIT_CTRL_RSP;
      INIT_CTRL_RSP: if (icb_rsp_valid) state_nxt = INIT_CSR;
      INIT_CSR:      if (icb_cmd_ready) state_nxt = INIT_CSR_RSP;
      INIT_CSR_RSP:  if (icb_rsp_valid) state_nxt = IDLE;
      IDLE: begin
        // With both valid, the requester not served last time wins.
        grant0 = req0_valid && (!req1_valid || rr_last);
        grant1 = req1_valid && (!req0_valid || !rr_last);
        if (grant0 || grant1) state_nxt = POLL;
      end
      POLL:          if (icb_cmd_ready) state_nxt = POLL_RSP;
      POLL_RSP:      if (icb_rsp_valid) state_nxt = icb_rsp_rdata[0] ? WRITE : POLL;
      WRITE:         if (icb_cmd_ready) state_nxt = WRITE_RSP;
      WRITE_RSP:     if (icb_rsp_valid) state_nxt = HOLD;
      HOLD:          if (hold_cnt == '0) state_nxt = IDLE;
      default:       state_nxt = INIT_CTRL;
    endcase
  end

  // Bus outputs decode the state register; gating with rst_n keeps them low
  // for the whole reset and drops an in-flight command the moment reset hits.
  always_comb begin
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = '0;
    icb_rsp_ready = 1'b0;
    busy          = 1'b0;
    if (rst_n) begin
      busy = (state != IDLE);
      case (state)
        INIT_CTRL: begin
          icb_cmd_valid = 1'b1;
          icb_cmd_addr  = CTRL_ADDR;
          icb_cmd_wdata = CTRL_INIT;
        end
        INIT_CSR: begin
          icb_cmd_valid = 1'b1;
          icb_cmd_addr  = CSR_ADDR;
          icb_cmd_wdata = {DIVISOR, 16'h0000};
        end
        POLL: begin
          icb_cmd_valid = 1'b1;
          icb_cmd_addr  = CSR_ADDR;
          icb_cmd_read  = 1'b1;
        end
        WRITE: begin
          icb_cmd_valid = 1'b1;
          icb_cmd_addr  = DATA_ADDR;
          icb_cmd_wdata = {24'h0, byte_q};
        end
        INIT_CTRL_RSP, INIT_CSR_RSP, POLL_RSP, WRITE_RSP: icb_rsp_ready = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_CTRL;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q     <= '0;
      id_q       <= 1'b0;
      rr_last    <= 1'b1;
      hold_cnt   <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      req0_ready <= grant0;
      req1_ready <= grant1;
      done       <= write_done;
      if (grant0 || grant1) begin
        byte_q  <= grant1 ? req1_data : req0_data;
        id_q    <= grant1;
        rr_last <= grant1;
      end
      if (write_done) begin
        done_id  <= id_q;
        hold_cnt <= HOLD_INIT;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
      end
      if (state == INIT_CSR_RSP && icb_rsp_valid) init_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: an ICB slave model with scripted CSR
// read data and write stalls, a table of byte requests, and reset sequences.
module tb_uart_tx_sched;

  localparam logic [31:0] DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] CSR_ADDR  = 32'h1000_0004;
  localparam logic [31:0] CTRL_ADDR = 32'h1000_0008;
  localparam logic [31:0] CTRL_INIT = 32'h0000_1111;
  localparam logic [31:0] CSR_INIT  = 32'h0036_0000;
  localparam int          HOLDOFF   = 8;
  localparam int          NV        = 9;

  logic        clk, rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        done, done_id, init_done, busy;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic        icb_rsp_valid, icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;

  uart_tx_sched #(
    .PA_SIZE(32), .DATA_ADDR(DATA_ADDR), .CSR_ADDR(CSR_ADDR), .CTRL_ADDR(CTRL_ADDR),
    .CTRL_INIT(CTRL_INIT), .DIVISOR(16'd54), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .done(done), .done_id(done_id), .init_done(init_done), .busy(busy),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
  } samp_t;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    int         zeros;
    logic       exp_id;
    logic [7:0] exp_byte;
  } vec_t;

  txn_t  txn_q[$];
  samp_t stall_q[$];
  vec_t  vecs[NV];

  int checks = 0, failures = 0;
  // Written by the test only; read by the slave.
  int csr_base = 0, csr_zeros = 0, stall_base = 0, stall_req = 0;
  // Written by the slave only.
  int read_total = 0, stall_total = 0;
  // Written by the monitor only.
  int r0_cnt = 0, r1_cnt = 0, done_cnt = 0, busy_run = 0, last_run = 0;
  logic done_id_seen = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ICB slave: 1-cycle responses, CSR reads return tx_ok=0 for the scripted
  // number of polls, optional stall of write commands.
  initial begin
    bit pend, pend_read, drop;
    pend = 0; pend_read = 0; drop = 0;
    icb_cmd_ready = 1'b1;
    icb_rsp_valid = 1'b0;
    icb_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (drop) begin
        icb_rsp_valid = 1'b0;
        drop = 0;
      end
      if (pend) begin
        icb_rsp_valid = 1'b1;
        if (pend_read) begin
          icb_rsp_rdata = ((read_total - csr_base) < csr_zeros) ? 32'h0 : 32'h1;
          read_total++;
        end else begin
          icb_rsp_rdata = 32'h0;
        end
        pend = 0;
      end
      icb_cmd_ready = 1'b1;
      if (icb_cmd_valid && !icb_cmd_read && (stall_total - stall_base) < stall_req) begin
        icb_cmd_ready = 1'b0;
        stall_total++;
        stall_q.push_back('{icb_cmd_valid, icb_cmd_addr, icb_cmd_wdata});
      end
      if (icb_cmd_valid && icb_cmd_ready) begin
        txn_q.push_back('{icb_cmd_addr, icb_cmd_read, icb_cmd_wdata});
        pend = 1;
        pend_read = icb_cmd_read;
      end
      if (icb_rsp_valid && icb_rsp_ready) drop = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (req0_ready) r0_cnt++;
      if (req1_ready) r1_cnt++;
      if (done) begin
        done_cnt++;
        done_id_seen = done_id;
      end
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        last_run = busy_run;
        busy_run = 0;
      end
    end
  end

  task automatic wait_done(input int base, output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (done_cnt > base) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Release reset mid high phase and count edges until init_done.
  task automatic release_and_check_init(input string tag);
    bit ok;
    int cyc, tb;
    tb = txn_q.size();
    @(posedge clk); #2;
    rst_n = 1'b1;
    ok = 0;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (init_done) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_init_seen"}, 64'(ok), 64'd1);
    check({tag, "_init_cycles"}, 64'(cyc), 64'd4);
    check({tag, "_init_txn_count"}, 64'(txn_q.size() - tb), 64'd2);
    if (txn_q.size() - tb == 2) begin
      check({tag, "_init0_addr"}, {31'h0, txn_q[tb].read, txn_q[tb].addr}, {32'h0, CTRL_ADDR});
      check({tag, "_init0_wdata"}, 64'(txn_q[tb].wdata), 64'(CTRL_INIT));
      check({tag, "_init1_addr"}, {31'h0, txn_q[tb+1].read, txn_q[tb+1].addr}, {32'h0, CSR_ADDR});
      check({tag, "_init1_wdata"}, 64'(txn_q[tb+1].wdata), 64'(CSR_INIT));
    end
  endtask

  initial begin
    bit   ok;
    int   tb, r0b, r1b, db, polls, writes, bad_poll;
    txn_t wr;

    vecs[0] = '{1'b1, 8'hAA, 1'b1, 8'h55, 0, 1'b0, 8'hAA};
    vecs[1] = '{1'b1, 8'hAA, 1'b1, 8'h55, 0, 1'b1, 8'h55};
    vecs[2] = '{1'b1, 8'hAA, 1'b1, 8'h55, 0, 1'b0, 8'hAA};
    vecs[3] = '{1'b1, 8'hAA, 1'b1, 8'h55, 0, 1'b1, 8'h55};
    vecs[4] = '{1'b1, 8'h41, 1'b0, 8'h00, 0, 1'b0, 8'h41};
    vecs[5] = '{1'b1, 8'h41, 1'b0, 8'h00, 0, 1'b0, 8'h41};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h7E, 3, 1'b1, 8'h7E};
    vecs[7] = '{1'b1, 8'h3C, 1'b0, 8'h00, 3, 1'b0, 8'h3C};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1, 1'b1, 8'hFF};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_ctrl_outputs",
          64'({icb_cmd_valid, busy, init_done, icb_rsp_ready, req0_ready, req1_ready,
               done, done_id, icb_cmd_read}), 64'd0);
    check("reset_cmd_bus", {icb_cmd_addr, icb_cmd_wdata}, 64'd0);
    release_and_check_init("boot");

    for (int i = 0; i < NV; i++) begin
      tb  = txn_q.size();
      r0b = r0_cnt;
      r1b = r1_cnt;
      db  = done_cnt;
      csr_base  = read_total;
      csr_zeros = vecs[i].zeros;
      req0_valid = vecs[i].v0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_data = vecs[i].d1;
      wait_done(db, ok);
      check($sformatf("v%0d_done_seen", i), 64'(ok), 64'd1);
      wait_idle(ok);
      check($sformatf("v%0d_idle_seen", i), 64'(ok), 64'd1);
      polls = 0; writes = 0; bad_poll = 0;
      wr = '{32'h0, 1'b0, 32'h0};
      for (int k = tb; k < txn_q.size(); k++) begin
        if (txn_q[k].read) begin
          polls++;
          if (txn_q[k].addr != CSR_ADDR) bad_poll++;
        end else begin
          writes++;
          wr = txn_q[k];
        end
      end
      check($sformatf("v%0d_polls", i), 64'(polls), 64'(vecs[i].zeros + 1));
      check($sformatf("v%0d_poll_addr", i), 64'(bad_poll), 64'd0);
      check($sformatf("v%0d_writes", i), 64'(writes), 64'd1);
      check($sformatf("v%0d_write_addr", i), 64'(wr.addr), 64'(DATA_ADDR));
      check($sformatf("v%0d_write_data", i), 64'(wr.wdata), {56'h0, vecs[i].exp_byte});
      check($sformatf("v%0d_ready0", i), 64'(r0_cnt - r0b), 64'(!vecs[i].exp_id));
      check($sformatf("v%0d_ready1", i), 64'(r1_cnt - r1b), 64'(vecs[i].exp_id));
      check($sformatf("v%0d_done_id", i), 64'(done_id_seen), 64'(vecs[i].exp_id));
      // Busy covers POLL, POLL_RSP, WRITE, WRITE_RSP and HOLDOFF hold cycles;
      // with the IDLE cycle a zero-wait byte takes 5+HOLDOFF = 13 cycles.
      check($sformatf("v%0d_busy_cycles", i), 64'(last_run + 1),
            64'(5 + HOLDOFF + 2 * vecs[i].zeros));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Write command stalled for 5 cycles must hold steady and issue once.
    tb = txn_q.size();
    db = done_cnt;
    r0b = r0_cnt;
    csr_base = read_total;
    csr_zeros = 0;
    stall_base = stall_total;
    stall_req = 5;
    req0_valid = 1'b1; req0_data = 8'h5A;
    wait_done(db, ok);
    check("stall_done_seen", 64'(ok), 64'd1);
    wait_idle(ok);
    req0_valid = 1'b0;
    check("stall_samples", 64'(stall_q.size()), 64'd5);
    for (int k = 0; k < stall_q.size(); k++) begin
      check($sformatf("stall%0d_valid_addr", k), {31'h0, stall_q[k].valid, stall_q[k].addr},
            {31'h0, 1'b1, DATA_ADDR});
      check($sformatf("stall%0d_wdata", k), 64'(stall_q[k].wdata), 64'h5A);
    end
    writes = 0;
    for (int k = tb; k < txn_q.size(); k++) if (!txn_q[k].read) writes++;
    check("stall_writes", 64'(writes), 64'd1);
    check("stall_ready0", 64'(r0_cnt - r0b), 64'd1);

    // Async reset while re-polling a CSR that never reports tx_ok.
    tb = txn_q.size();
    csr_base = read_total;
    csr_zeros = 1000;
    req0_valid = 1'b1; req0_data = 8'h3C;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (icb_rsp_ready && txn_q.size() > tb + 1 && txn_q[txn_q.size()-1].read) begin
        ok = 1;
        break;
      end
    end
    check("rst_reached_poll_rsp", 64'(ok), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 64'({icb_cmd_valid, icb_rsp_ready, busy, init_done, req0_ready, done}),
          64'd0);
    csr_zeros = 0;
    csr_base = read_total;
    req0_valid = 1'b1; req0_data = 8'h3C;
    req1_valid = 1'b1; req1_data = 8'hC3;
    r0b = r0_cnt;
    r1b = r1_cnt;
    db  = done_cnt;
    repeat (2) @(posedge clk);
    release_and_check_init("rerun");
    tb = txn_q.size();
    wait_done(db, ok);
    check("rerun_done_seen", 64'(ok), 64'd1);
    wait_idle(ok);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rerun_first_grant0", 64'(r0_cnt - r0b), 64'd1);
    check("rerun_no_grant1", 64'(r1_cnt - r1b), 64'd0);
    check("rerun_done_id", 64'(done_id_seen), 64'd0);
    wr = '{32'h0, 1'b0, 32'h0};
    for (int k = tb; k < txn_q.size(); k++) if (!txn_q[k].read) wr = txn_q[k];
    check("rerun_write_data", {wr.addr, wr.wdata}, {DATA_ADDR, 32'h0000_003C});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Bus-master sequencer that owns the ICB slave port of the UART top and shares its transmitter between two byte requesters. After reset it configures the UART: control register first, then the divisor field of the CSR. It then arbitrates round-robin between requester 0 and requester 1. For each granted byte it polls CSR.tx_ok, writes the data register, and signals completion to the winning requester. It sits between software-less producers (e.g. a debug trace path and a boot message ROM) and the UART top, replacing the CPU as ICB master.

## Interface
Parameters:
- PA_SIZE, 32, ICB address width; matches the UART top address width
- DATA_ADDR, 32'h1000_0000, UART data register address
- CSR_ADDR, 32'h1000_0004, UART CSR address; tx_ok is bit 0, divisor is bits 31:16
- CTRL_ADDR, 32'h1000_0008, UART control register address
- CTRL_INIT, 32'h0000_1111, value written to CTRL at init (baud_en, tx_en, rx_en, no parity)
- DIVISOR, 16'd54, divisor written to CSR[31:16] at init
- HOLDOFF, 8, cycles to wait after a data write before the next poll; must be ≥1

Ports:
- clk  in  1  single clock; all logic is posedge clk
- rst_n  in  1  reset, asynchronous assert, active-low
- req0_valid / req1_valid  in  1  requester has a byte
- req0_data / req1_data  in  8  byte to send; held stable while valid
- req0_ready / req1_ready  out  1  one-cycle pulse: byte accepted (latched)
- done  out  1  one-cycle pulse: data write response received
- done_id  out  1  requester that owns the done pulse (0/1)
- init_done  out  1  high once both init writes complete; stays high until reset
- busy  out  1  high in every state except IDLE
- icb_cmd_valid  out  1  ICB command valid
- icb_cmd_ready  in  1  ICB command ready
- icb_cmd_addr  out  PA_SIZE  ICB address
- icb_cmd_read  out  1  1 = read, 0 = write
- icb_cmd_wdata  out  32  write data
- icb_rsp_valid  in  1  ICB response valid
- icb_rsp_ready  out  1  ICB response ready
- icb_rsp_rdata  in  32  read data

## Operation
- Reset state: INIT_CTRL. All outputs are 0 during reset, including init_done, busy, cmd_valid, req*_ready and done. Internal state also resets: rr_last=1 (so requester 0 wins first), hold_cnt=0, byte latch=0.
- FSM states: INIT_CTRL, INIT_CTRL_RSP, INIT_CSR, INIT_CSR_RSP, IDLE, POLL, POLL_RSP, WRITE, WRITE_RSP, HOLD.
- Command states are INIT_CTRL, INIT_CSR, POLL and WRITE. In each, cmd_valid=1 with registered addr/read/wdata, held stable until cmd_ready is sampled high. Then the FSM moves to the matching _RSP state.
- Command contents per state:
  - INIT_CTRL: CTRL_ADDR, write, CTRL_INIT.
  - INIT_CSR: CSR_ADDR, write, {DIVISOR,16'h0}.
  - POLL: CSR_ADDR, read, wdata 0.
  - WRITE: DATA_ADDR, write, {24'h0, byte}.
- _RSP states: rsp_ready=1, cmd_valid=0. The FSM waits for rsp_valid. Outside _RSP states rsp_ready=0.
- INIT_CSR_RSP → IDLE, and init_done is set in the same edge.
- IDLE arbitration:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant !rr_last.
  - On grant: latch data and id, pulse reqN_ready for one cycle, update rr_last=id, go to POLL.
- POLL_RSP: if rdata[0]=1, go to WRITE; otherwise go to POLL (re-poll, no limit).
- WRITE_RSP: on rsp_valid, pulse done with done_id=latched id, load hold_cnt=HOLDOFF-1, go to HOLD.
- HOLD: decrement hold_cnt; at 0 go to IDLE. This covers the baud-domain delay before tx_ok falls.
- Requester inputs are ignored outside IDLE. A requester deasserting valid before its grant is legal; nothing is latched.

## Timing
- Minimum byte cycle, with zero-wait cmd_ready and 1-cycle rsp: IDLE(1) + POLL(1) + POLL_RSP(1) + WRITE(1) + WRITE_RSP(1) + HOLD(HOLDOFF) = 5+HOLDOFF cycles from grant edge to return to IDLE.
- reqN_ready pulses the cycle after IDLE samples valid. done pulses the cycle after rsp_valid is seen in WRITE_RSP.
- Init takes a minimum of 4 cycles after reset release before IDLE.
- Async reset mid-transaction drops cmd_valid immediately and restarts init. Any pending rsp after reset is ignored because rsp_ready=0 in INIT_CTRL.
- A response arriving in the same cycle as the command handshake is not accepted. Responses are only taken in _RSP states.

## Test plan
- Reset release with an always-ready, 1-cycle-response slave → exactly two writes in order: CTRL_ADDR/32'h0000_1111, then CSR_ADDR/32'h0036_0000. init_done rises 4 cycles after release.
- req0_valid with data 8'h41, CSR returns 32'h1 → one CSR read, then a DATA_ADDR write of 32'h41. done=1 with done_id=0. busy low again 13 cycles after grant.
- Both requesters valid continuously (8'hAA on 0, 8'h55 on 1) → grants alternate 0,1,0,1. The write stream is AA,55,AA,55.
- CSR returns tx_ok=0 three times, then 1 → exactly 4 CSR reads precede the data write. req0_ready pulses only once.
- cmd_ready held low 5 cycles during WRITE → cmd_valid/addr/wdata stay stable for all 5 cycles. Exactly one write is issued.
- rst_n asserted while in POLL_RSP → cmd_valid=0 asynchronously. After release, the init sequence repeats and the first grant goes to req0.
